// File: rtl/alu_sweep_pkg.sv
// Shared types and constants for the ALU sweep driver and its MISR.
package alu_sweep_pkg;

    localparam int OPND_W = 4;
    localparam int OPC_W  = 4;
    localparam int RES_W  = 8;

    localparam logic [7:0] DEF_MISR_POLY = 8'h07;
    localparam logic [7:0] DEF_MISR_SEED = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_e;

    // One MISR step: shift left, apply feedback on the dropped MSB, fold in the new sample.
    function automatic logic [7:0] misr_step(input logic [7:0] sig,
                                             input logic [7:0] poly,
                                             input logic [7:0] din);
        return {sig[6:0], 1'b0} ^ (sig[7] ? poly : 8'h00) ^ din;
    endfunction

endpackage

// File: rtl/alu_sweep_driver_misr8.sv
// 8-bit multiple-input signature register; seed is also the reset value.
module misr8
    import alu_sweep_pkg::*;
#(
    parameter logic [7:0] POLY = DEF_MISR_POLY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_seed,
    input  logic [7:0] seed,
    input  logic       shift_en,
    input  logic [7:0] data_in,
    output logic [7:0] sig
);

    logic [7:0] sig_q;
    logic [7:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load_seed) begin
            sig_d = seed;
        end else if (shift_en) begin
            sig_d = misr_step(sig_q, POLY, data_in);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= seed;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/alu_sweep_driver.sv
// Sweeps every ALU opcode, samples each result and compacts them into a MISR signature.
// Optional per-opcode result buffer enabled by defining ALU_SWEEP_RESULT_BUF_EN.
module alu_sweep_driver
    import alu_sweep_pkg::*;
#(
    parameter int         NUM_OPS     = 13,
    parameter int         HOLD_CYCLES = 2,
    parameter logic [7:0] MISR_POLY   = DEF_MISR_POLY,
    parameter logic [7:0] MISR_SEED   = DEF_MISR_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OPND_W-1:0] op_a,
    input  logic [OPND_W-1:0] op_b,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_op,
    input  logic [RES_W-1:0]  alu_result,
    output logic              busy,
    output logic              done,
    output logic [RES_W-1:0]  signature,
    input  logic [OPC_W-1:0]  rd_idx,
    output logic [RES_W-1:0]  rd_data
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0]  HC_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [OPC_W-1:0] OP_LAST = OPC_W'(NUM_OPS - 1);

    sweep_state_e      state_q, state_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [OPND_W-1:0] alu_a_q, alu_a_d;
    logic [OPND_W-1:0] alu_b_q, alu_b_d;
    logic [OPC_W-1:0]  alu_op_q, alu_op_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic start_acc;
    logic sample;
    logic last_op;

    assign start_acc = start && (state_q != ST_DRIVE);
    assign sample    = (state_q == ST_DRIVE) && (hold_cnt_q == HC_LAST);
    assign last_op   = (alu_op_q == OP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_DRIVE;
            ST_DRIVE:         if (sample && last_op) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        busy_d     = busy_q;
        done_d     = done_q;
        if (start_acc) begin
            alu_a_d    = op_a;
            alu_b_d    = op_b;
            alu_op_d   = '0;
            hold_cnt_d = '0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
        end else if (state_q == ST_DRIVE) begin
            if (sample) begin
                hold_cnt_d = '0;
                if (last_op) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    alu_op_d = alu_op_q + 1'b1;
                end
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    misr8 #(
        .POLY(MISR_POLY)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .load_seed(start_acc),
        .seed     (MISR_SEED),
        .shift_en (sample),
        .data_in  (alu_result),
        .sig      (signature)
    );

`ifdef ALU_SWEEP_RESULT_BUF_EN
    // Sized to the full opcode space; entries at or above NUM_OPS are never written.
    logic [RES_W-1:0] res_buf_q [16];
    logic [RES_W-1:0] res_buf_d [16];

    always_comb begin
        res_buf_d = res_buf_q;
        if (sample) begin
            res_buf_d[alu_op_q] = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                res_buf_q[i] <= '0;
            end
        end else begin
            res_buf_q <= res_buf_d;
        end
    end

    assign rd_data = ({1'b0, rd_idx} < 5'(NUM_OPS)) ? res_buf_q[rd_idx] : '0;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx;
    assign rd_data       = '0;
`endif

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
